top_module_sync: RTL and testbench

- Registered smart-home controller with three functions: a 4-bit password door lock, a light-level compensator, and a temperature-driven climate controller.
- Top-level of the small-automation subsystem.
- The lamp and climate outputs are only active while the lock reports "unlocked" (occupant present).

---
 rtl/top_module_sync.sv | 140 ++++++++++++++
 tb/tb_top_module_sync.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/top_module_sync.sv
// Smart-home controller: 4-bit code lock, lamp compensation, climate control.
// Ports: clk, rst_n (async low), PA/light/TEMP in; Lock_out, light_out,
//        fan_out, FAN, AC, WIND out (all registered).
// Optional: define SMART_LOCKOUT_EN to add wrong-try counting and penalty.
module top_module_sync #(
    parameter logic [3:0] PASSWORD       = 4'b0010,
    parameter int         AC_ON          = 10,
    parameter int         AC_HYST        = 2,
    parameter int         MAX_TRIES      = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] PA,
    input  logic [3:0] light,
    input  logic [3:0] TEMP,
    output logic       Lock_out,
    output logic [3:0] light_out,
    output logic [3:0] fan_out,
    output logic       FAN,
    output logic       AC,
    output logic       WIND
);

    localparam logic [3:0] AC_ON_C  = 4'(AC_ON);
    localparam logic [3:0] AC_OFF_C = 4'(AC_ON - AC_HYST);

    logic       w_penalty;
    logic       w_unlock;
    logic       w_ac_next;
    logic       r_ac_state;
    logic [3:0] w_fan_out;
    logic       w_fan;
    logic       w_wind;

`ifdef SMART_LOCKOUT_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0] TRY_MAX  = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [CW-1:0] PEN_LEN  = CW'(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] PEN_ONE  = CW'(1);

    logic [3:0]    r_pa_prev;
    logic [TW-1:0] r_tries;
    logic [CW-1:0] r_pen_cnt;
    logic          w_attempt;

    assign w_penalty = (r_pen_cnt != '0);
    // An attempt is a fresh, non-idle code.
    assign w_attempt = (PA != 4'd0) && (PA != r_pa_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pa_prev <= 4'd0;
            r_tries   <= '0;
            r_pen_cnt <= '0;
        end else begin
            r_pa_prev <= PA;
            if (w_penalty) begin
                // Entries during the penalty are ignored.
                r_pen_cnt <= r_pen_cnt - PEN_ONE;
                if (r_pen_cnt == PEN_ONE) begin
                    r_tries <= '0;
                end
            end else if (w_attempt) begin
                if (PA == PASSWORD) begin
                    r_tries <= '0;
                end else if (r_tries == TRY_LAST) begin
                    r_tries   <= TRY_MAX;
                    r_pen_cnt <= PEN_LEN;
                end else begin
                    r_tries <= r_tries + 1'b1;
                end
            end
        end
    end
`else
    assign w_penalty = 1'b0;
`endif

    assign w_unlock = (PA == PASSWORD) && !w_penalty;

    // AC hysteresis only evolves while someone is home.
    always_comb begin
        w_ac_next = r_ac_state;
        if (w_unlock) begin
            if (TEMP >= AC_ON_C) begin
                w_ac_next = 1'b1;
            end else if (TEMP <= AC_OFF_C) begin
                w_ac_next = 1'b0;
            end
        end
    end

    always_comb begin
        w_fan_out = 4'd0;
        w_fan     = 1'b0;
        w_wind    = 1'b0;
        if (TEMP >= AC_ON_C) begin
            w_fan     = 1'b1;
            w_fan_out = 4'hF;
        end else if (TEMP >= 4'd5) begin
            w_fan     = 1'b1;
            w_fan_out = TEMP - 4'd4;
        end else begin
            // Never open the window against a running AC.
            w_wind = !w_ac_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac_state <= 1'b0;
            Lock_out   <= 1'b0;
            light_out  <= 4'd0;
            fan_out    <= 4'd0;
            FAN        <= 1'b0;
            AC         <= 1'b0;
            WIND       <= 1'b0;
        end else begin
            r_ac_state <= w_ac_next;
            Lock_out   <= w_unlock;
            if (w_unlock) begin
                light_out <= 4'hF - light;
                fan_out   <= w_fan_out;
                FAN       <= w_fan;
                AC        <= w_ac_next;
                WIND      <= w_wind;
            end else begin
                light_out <= 4'd0;
                fan_out   <= 4'd0;
                FAN       <= 1'b0;
                AC        <= 1'b0;
                WIND      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_top_module_sync.sv
// Directed bench for top_module_sync.
// Ports driven: clk, rst_n, PA, light, TEMP; all outputs checked.
module tb_top_module_sync;

    logic       clk;
    logic       rst_n;
    logic [3:0] PA;
    logic [3:0] light;
    logic [3:0] TEMP;
    logic       Lock_out;
    logic [3:0] light_out;
    logic [3:0] fan_out;
    logic       FAN;
    logic       AC;
    logic       WIND;

    int n_assert = 0;
    int n_fail   = 0;

    top_module_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PA        (PA),
        .light     (light),
        .TEMP      (TEMP),
        .Lock_out  (Lock_out),
        .light_out (light_out),
        .fan_out   (fan_out),
        .FAN       (FAN),
        .AC        (AC),
        .WIND      (WIND)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk,
                           input logic [3:0] lo, input logic [3:0] fo,
                           input logic fn, input logic ac, input logic wd);
        chk({tag, ".Lock_out"},  {3'd0, Lock_out}, {3'd0, lk});
        chk({tag, ".light_out"}, light_out, lo);
        chk({tag, ".fan_out"},   fan_out, fo);
        chk({tag, ".FAN"},       {3'd0, FAN}, {3'd0, fn});
        chk({tag, ".AC"},        {3'd0, AC}, {3'd0, ac});
        chk({tag, ".WIND"},      {3'd0, WIND}, {3'd0, wd});
    endtask

    task automatic step(input logic [3:0] pa, input logic [3:0] l,
                        input logic [3:0] t);
        PA    = pa;
        light = l;
        TEMP  = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        PA    = 4'b0010;
        light = 4'd3;
        TEMP  = 4'd12;
        step(4'b0010, 4'd3, 4'd12);
        step(4'b0010, 4'd3, 4'd12);
        chk_all("reset", 0, 4'd0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;
        step(4'b0010, 4'd3, 4'd12);
        chk_all("rel", 1, 4'd12, 4'hF, 1, 1, 0);

        // lock sequence
        step(4'b0000, 4'd3, 4'd12);
        chk_all("pa0000", 0, 4'd0, 4'd0, 0, 0, 0);
        step(4'b0001, 4'd3, 4'd12);
        chk("pa0001", {3'd0, Lock_out}, 4'd0);
        step(4'b0110, 4'd3, 4'd12);
        chk("pa0110", {3'd0, Lock_out}, 4'd0);
`ifndef SMART_LOCKOUT_EN
        step(4'b1110, 4'd3, 4'd12);
        chk("pa1110", {3'd0, Lock_out}, 4'd0);
`endif
        step(4'b0010, 4'd3, 4'd12);
        chk_all("pa0010", 1, 4'd12, 4'hF, 1, 1, 0);
        step(4'b0010, 4'd3, 4'd12);
        chk("hold", {3'd0, Lock_out}, 4'd1);

        // light
        step(4'b0010, 4'd0, 4'd12);
        chk("light0", light_out, 4'd15);
        step(4'b0010, 4'd5, 4'd12);
        chk("light5", light_out, 4'd10);
        step(4'b0010, 4'd15, 4'd12);
        chk("light15", light_out, 4'd0);
        step(4'b0001, 4'd5, 4'd12);
        chk_all("relock", 0, 4'd0, 4'd0, 0, 0, 0);

        // climate sweep (AC state is 1 on entry)
        step(4'b0010, 4'd5, 4'd3);
        chk_all("t3", 1, 4'd10, 4'd0, 0, 0, 1);
        step(4'b0010, 4'd5, 4'd7);
        chk_all("t7", 1, 4'd10, 4'd3, 1, 0, 0);
        step(4'b0010, 4'd5, 4'd11);
        chk_all("t11", 1, 4'd10, 4'hF, 1, 1, 0);
        step(4'b0010, 4'd5, 4'd9);
        chk_all("t9", 1, 4'd10, 4'd5, 1, 1, 0);
        step(4'b0010, 4'd5, 4'd8);
        chk_all("t8", 1, 4'd10, 4'd4, 1, 0, 0);
        step(4'b0010, 4'd5, 4'd4);
        chk_all("t4", 1, 4'd10, 4'd0, 0, 0, 1);
        step(4'b0010, 4'd5, 4'd5);
        chk_all("t5", 1, 4'd10, 4'd1, 1, 0, 0);
        step(4'b0010, 4'd5, 4'd15);
        chk_all("t15", 1, 4'd10, 4'hF, 1, 1, 0);

        // gating: AC state survives a locked period even at low TEMP
        step(4'b0010, 4'd5, 4'd11);
        chk("g_t11", {3'd0, AC}, 4'd1);
        step(4'b0000, 4'd5, 4'd3);
        chk_all("g_lock", 0, 4'd0, 4'd0, 0, 0, 0);
        step(4'b0010, 4'd5, 4'd9);
        chk_all("g_back", 1, 4'd10, 4'd5, 1, 1, 0);

        // asynchronous reset mid-operation
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async", 0, 4'd0, 4'd0, 0, 0, 0);
        step(4'b0010, 4'd5, 4'd9);
        chk_all("async_hold", 0, 4'd0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;
        step(4'b0010, 4'd5, 4'd9);
        chk_all("after_rst", 1, 4'd10, 4'd5, 1, 0, 0);

        // wrong tries then the correct code
        step(4'b0000, 4'd5, 4'd9);
        step(4'b0001, 4'd5, 4'd9);
        chk("try1", {3'd0, Lock_out}, 4'd0);
        step(4'b0011, 4'd5, 4'd9);
        chk("try2", {3'd0, Lock_out}, 4'd0);
        step(4'b0111, 4'd5, 4'd9);
        chk("try3", {3'd0, Lock_out}, 4'd0);
`ifdef SMART_LOCKOUT_EN
        for (int i = 0; i < 16; i++) begin
            step(4'b0010, 4'd5, 4'd9);
            chk($sformatf("pen%0d", i), {3'd0, Lock_out}, 4'd0);
        end
        step(4'b0010, 4'd5, 4'd9);
        chk_all("pen_end", 1, 4'd10, 4'd5, 1, 0, 0);
`else
        step(4'b0010, 4'd5, 4'd9);
        chk_all("no_pen", 1, 4'd10, 4'd5, 1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
